// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data-memory arbiter state encodings, funct3 size codes
// and the debug request record held by the arbiter.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_STALL = 2'd2
  } arb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dbg_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and data-memory signals around dmem_arbiter.
// slave = arbiter side, master = surrounding core/debug/memory side.
interface dmem_arbiter_if;

  logic        core_re;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_funct3;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        dbg_valid;
  logic        dbg_ready;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [2:0]  dbg_funct3;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_dout;

  modport slave (
    input  core_re, core_we, core_addr, core_wdata, core_funct3,
    output core_rdata, core_stall,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_we, mem_addr, mem_din, mem_funct3,
    input  mem_dout
  );

  modport master (
    output core_re, core_we, core_addr, core_wdata, core_funct3,
    input  core_rdata, core_stall,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_addr, mem_din, mem_funct3,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous reset; only built with DMEM_ARB_STATS_EN,
// since the arbiter statistics are its only user.
`ifdef DMEM_ARB_STATS_EN
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core has priority, debug requests get bounded latency
// via a starvation counter and a forced stall. DMEM_ARB_STATS_EN adds grant/stall counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no debug request held; dbg_ready high
// ARB_PEND  | request held; granted on the first core-idle cycle
// ARB_STALL | starvation limit hit; core stalled, debug request granted
module dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_grants,
  output logic [15:0]   stat_stalls
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  dbg_req_t    hold_q;
  logic [7:0]  wait_q, wait_d, wait_inc;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        core_busy;
  logic        accept;
  logic        grant;
  logic        rd_grant;

  assign core_busy = bus.core_re | bus.core_we;
  assign accept    = bus.dbg_valid & (state_q == ARB_IDLE);
  assign wait_inc  = wait_q + 8'd1;
  assign rd_grant  = grant & ~hold_q.we;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    grant   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d = ARB_PEND;
          wait_d  = '0;
        end
      end
      ARB_PEND: begin
        if (!core_busy) begin
          grant   = 1'b1;
          state_d = ARB_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_inc;
          // Compare the post-increment count so the stall lands STARVE_LIMIT+1 cycles after accept
          if (wait_inc == LIMIT) begin
            state_d = ARB_STALL;
          end
        end
      end
      ARB_STALL: begin
        grant   = 1'b1;
        state_d = ARB_IDLE;
        wait_d  = '0;
      end
      default: begin
        state_d = ARB_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    bus.mem_we     = bus.core_we;
    bus.mem_addr   = bus.core_addr;
    bus.mem_din    = bus.core_wdata;
    bus.mem_funct3 = bus.core_funct3;
    if (grant) begin
      bus.mem_we     = hold_q.we;
      bus.mem_addr   = hold_q.addr;
      bus.mem_din    = hold_q.wdata;
      bus.mem_funct3 = hold_q.funct3;
    end
  end

  assign bus.core_rdata = bus.mem_dout;
  assign bus.core_stall = (state_q == ARB_STALL);
  assign bus.dbg_ready  = (state_q == ARB_IDLE);
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      wait_q   <= '0;
      hold_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rvalid_q <= rd_grant;
      if (accept) begin
        hold_q <= '{we: bus.dbg_we, addr: bus.dbg_addr,
                    wdata: bus.dbg_wdata, funct3: bus.dbg_funct3};
      end
      if (rd_grant) begin
        rdata_q <= bus.mem_dout;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(.WIDTH(16)) u_grant_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant),
    .count (stat_grants)
  );

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == ARB_STALL),
    .count (stat_stalls)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a request-level reference model and a shadow memory.
module tb_dmem_arbiter;
  import rv32i_pkg::*;

  localparam int LIM = 3;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_grants, stat_stalls;
`endif

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  // data_memory stand-in: combinational read, synchronous write, word granular
  logic [31:0] mem [0:63];
  assign bus.mem_dout = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_din;
    end
  end

  int n_vec, n_bad;

  // Reference model: one held request, its count of busy cycles waited, and whether
  // the next cycle is the forced service cycle.
  logic [31:0] smem [0:63];
  bit          m_pend, m_force;
  int          m_waited;
  dbg_req_t    m_req;
  bit          m_rv;
  logic [31:0] m_rd;
  logic [15:0] m_grants, m_stalls;

  logic        exp_ready, exp_stall, exp_grant, exp_mwe, exp_rv;
  logic [31:0] exp_maddr, exp_mdin, exp_rd;
  logic [2:0]  exp_mf3;

  task automatic model_clear();
    m_pend = 0; m_force = 0; m_waited = 0; m_req = '0;
    m_rv = 0; m_rd = 32'h0; m_grants = 16'h0; m_stalls = 16'h0;
  endtask

  task automatic model_eval();
    bit busy;
    busy      = bus.core_re || bus.core_we;
    exp_ready = !m_pend;
    exp_stall = m_force;
    exp_grant = m_force || (m_pend && !busy);
    if (exp_grant) begin
      exp_mwe = m_req.we; exp_maddr = m_req.addr; exp_mdin = m_req.wdata; exp_mf3 = m_req.funct3;
    end else begin
      exp_mwe = bus.core_we; exp_maddr = bus.core_addr; exp_mdin = bus.core_wdata; exp_mf3 = bus.core_funct3;
    end
    exp_rv = m_rv;
    exp_rd = m_rd;
  endtask

  task automatic model_commit();
    bit busy;
    busy = bus.core_re || bus.core_we;
    if (exp_mwe) smem[exp_maddr[7:2]] = exp_mdin;
    if (reset) begin
      model_clear();
    end else begin
      m_rv = exp_grant && !m_req.we;
      if (m_rv) m_rd = smem[m_req.addr[7:2]];
      if (exp_grant && m_grants != 16'hFFFF) m_grants++;
      if (exp_stall && m_stalls != 16'hFFFF) m_stalls++;
      if (exp_grant) begin
        m_pend = 0; m_force = 0;
      end else if (m_pend && busy) begin
        m_waited++;
        if (m_waited == LIM) m_force = 1;
      end
      if (exp_ready && bus.dbg_valid) begin
        m_pend = 1; m_waited = 0;
        m_req = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata, funct3: bus.dbg_funct3};
      end
    end
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    bus.core_re = 0; bus.core_we = 0; bus.core_addr = 32'h0; bus.core_wdata = 32'h0; bus.core_funct3 = F3_LW;
    bus.dbg_valid = 0; bus.dbg_we = 0; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0; bus.dbg_funct3 = F3_LW;
  endtask

  task automatic test_reset();
    reset = 1; set_idle();
    bus.core_addr = 32'h84; bus.core_wdata = 32'h1; bus.core_funct3 = F3_LH;
    repeat (2) begin eval_cycle(); advance(); end
    reset = 0;
    eval_cycle();
    n_vec++; if (bus.dbg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.dbg_ready); end
    n_vec++; if (bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.core_stall); end
    n_vec++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", bus.dbg_rvalid); end
    n_vec++; if (bus.dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.dbg_rdata); end
    n_vec++; if (bus.mem_addr !== 32'h84) begin n_bad++; $display("FAIL reset_maddr: got %h want 84", bus.mem_addr); end
    n_vec++; if (bus.mem_funct3 !== F3_LH) begin n_bad++; $display("FAIL reset_mf3: got %h want %h", bus.mem_funct3, F3_LH); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mwe: got %b want 0", bus.mem_we); end
    advance();
  endtask

  task automatic test_idle_write_read();
    set_idle();
    bus.dbg_valid = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'hDEADBEEF; bus.dbg_funct3 = F3_LW;
    eval_cycle();
    n_vec++; if (bus.dbg_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", bus.dbg_ready); end
    advance();
    bus.dbg_valid = 0;
    eval_cycle();
    n_vec++; if (bus.dbg_ready !== 1'b0) begin n_bad++; $display("FAIL wr_held_ready: got %b want 0", bus.dbg_ready); end
    n_vec++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_grant_we: got %b want 1", bus.mem_we); end
    n_vec++; if (bus.mem_addr !== 32'h40) begin n_bad++; $display("FAIL wr_grant_addr: got %h want 40", bus.mem_addr); end
    n_vec++; if (bus.mem_din !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_grant_din: got %h want deadbeef", bus.mem_din); end
    advance();
    n_vec++; if (mem[16] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_commit: got %h want deadbeef", mem[16]); end
    bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_wdata = 32'h0;
    eval_cycle();
    n_vec++; if (bus.dbg_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %b want 1", bus.dbg_ready); end
    advance();
    bus.dbg_valid = 0;
    eval_cycle();
    n_vec++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h40) begin n_bad++; $display("FAIL rd_grant: got we=%b addr=%h want we=0 addr=40", bus.mem_we, bus.mem_addr); end
    n_vec++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_early_rvalid: got %b want 0", bus.dbg_rvalid); end
    advance();
    eval_cycle();
    n_vec++; if (bus.dbg_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", bus.dbg_rvalid); end
    n_vec++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", bus.dbg_rdata); end
    advance();
    eval_cycle();
    n_vec++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse_width: got %b want 0", bus.dbg_rvalid); end
    advance();
  endtask

  task automatic test_starve();
    int stall_cnt, stall_at;
    logic [5:0] idx;
    stall_cnt = 0; stall_at = -1;
    set_idle();
    bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h40; bus.dbg_funct3 = F3_LW;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) bus.dbg_valid = 0;
      bus.core_we = 1;
      bus.core_addr = {24'h0, 1'b1, 5'($urandom), 2'b00};
      bus.core_wdata = $urandom;
      idx = bus.core_addr[7:2];
      eval_cycle();
      if (bus.core_stall === 1'b1) begin stall_cnt++; stall_at = i; end
      n_vec++; if (bus.mem_we !== exp_mwe || bus.mem_addr !== exp_maddr) begin n_bad++; $display("FAIL starve_mux c%0d: got we=%b addr=%h want we=%b addr=%h", i, bus.mem_we, bus.mem_addr, exp_mwe, exp_maddr); end
      if (i == LIM + 2) begin
        n_vec++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL starve_rdata: got v=%b d=%h want v=1 d=deadbeef", bus.dbg_rvalid, bus.dbg_rdata); end
      end
      advance();
      n_vec++; if (mem[idx] !== smem[idx]) begin n_bad++; $display("FAIL starve_mem c%0d: got %h want %h", i, mem[idx], smem[idx]); end
    end
    n_vec++; if (stall_cnt != 1) begin n_bad++; $display("FAIL starve_stall_count: got %0d want 1", stall_cnt); end
    n_vec++; if (stall_at != LIM + 1) begin n_bad++; $display("FAIL starve_stall_cycle: got %0d want %0d", stall_at, LIM + 1); end
    set_idle();
  endtask

  task automatic test_core_load_pending();
    logic [31:0] d;
    d = $urandom;
    set_idle();
    bus.core_we = 1; bus.core_addr = 32'h80; bus.core_wdata = 32'hA5A50F0F;
    eval_cycle(); advance();
    set_idle();
    bus.dbg_valid = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h44; bus.dbg_wdata = d;
    eval_cycle(); advance();
    bus.dbg_valid = 0;
    for (int i = 0; i < 2; i++) begin
      bus.core_re = 1; bus.core_addr = 32'h80;
      eval_cycle();
      n_vec++; if (bus.core_rdata !== 32'hA5A50F0F) begin n_bad++; $display("FAIL load_rdata c%0d: got %h want a5a50f0f", i, bus.core_rdata); end
      n_vec++; if (bus.dbg_ready !== 1'b0 || bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL load_pending c%0d: got ready=%b stall=%b want 0 0", i, bus.dbg_ready, bus.core_stall); end
      n_vec++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h80) begin n_bad++; $display("FAIL load_mux c%0d: got we=%b addr=%h want 0 80", i, bus.mem_we, bus.mem_addr); end
      advance();
    end
    set_idle();
    eval_cycle();
    n_vec++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h44) begin n_bad++; $display("FAIL load_then_grant: got we=%b addr=%h want 1 44", bus.mem_we, bus.mem_addr); end
    advance();
    n_vec++; if (mem[17] !== d) begin n_bad++; $display("FAIL load_then_commit: got %h want %h", mem[17], d); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 0; i < 8; i++) begin
      bus.dbg_valid = 1; bus.dbg_we = 1'($urandom); bus.dbg_wdata = $urandom;
      bus.dbg_addr = {24'h0, 2'b00, 4'($urandom), 2'b00};
      eval_cycle();
      n_vec++; if (bus.dbg_ready !== ((i % 2) == 0)) begin n_bad++; $display("FAIL b2b_ready c%0d: got %b want %b", i, bus.dbg_ready, (i % 2) == 0); end
      n_vec++; if (bus.mem_we !== exp_mwe || bus.mem_addr !== exp_maddr || bus.dbg_rvalid !== exp_rv) begin n_bad++; $display("FAIL b2b_model c%0d: got we=%b addr=%h rv=%b want %b %h %b", i, bus.mem_we, bus.mem_addr, bus.dbg_rvalid, exp_mwe, exp_maddr, exp_rv); end
      advance();
    end
    set_idle();
    eval_cycle(); advance();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = ~smem[18];
    set_idle();
    bus.dbg_valid = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h48; bus.dbg_wdata = d;
    eval_cycle(); advance();
    set_idle();
    reset = 1; bus.core_re = 1; bus.core_addr = 32'h80;
    eval_cycle(); advance();
    reset = 0; set_idle();
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      if (i == 0) begin
        n_vec++; if (bus.dbg_ready !== 1'b1 || bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_state: got ready=%b stall=%b want 1 0", bus.dbg_ready, bus.core_stall); end
      end
      n_vec++; if (bus.dbg_rvalid !== 1'b0 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet c%0d: got rv=%b we=%b want 0 0", i, bus.dbg_rvalid, bus.mem_we); end
      advance();
    end
    n_vec++; if (mem[18] !== smem[18] || mem[18] === d) begin n_bad++; $display("FAIL rstmid_mem: got %h want %h", mem[18], smem[18]); end
  endtask

  task automatic test_random();
    logic [5:0] idx;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) == 0);
      bus.core_re = ($urandom_range(2) == 0);
      bus.core_we = ($urandom_range(2) == 0);
      bus.core_addr = {24'h0, 6'($urandom), 2'b00};
      bus.core_wdata = $urandom;
      bus.core_funct3 = 3'($urandom);
      bus.dbg_valid = 1'($urandom);
      bus.dbg_we = 1'($urandom);
      bus.dbg_addr = {24'h0, 6'($urandom), 2'b00};
      bus.dbg_wdata = $urandom;
      bus.dbg_funct3 = 3'($urandom);
      eval_cycle();
      idx = exp_maddr[7:2];
      n_vec++; if (bus.core_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", i, bus.core_stall, exp_stall); end
      n_vec++; if (bus.dbg_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", i, bus.dbg_ready, exp_ready); end
      n_vec++; if (bus.mem_we !== exp_mwe) begin n_bad++; $display("FAIL rnd_mwe c%0d: got %b want %b", i, bus.mem_we, exp_mwe); end
      n_vec++; if (bus.mem_addr !== exp_maddr) begin n_bad++; $display("FAIL rnd_maddr c%0d: got %h want %h", i, bus.mem_addr, exp_maddr); end
      n_vec++; if (bus.mem_din !== exp_mdin) begin n_bad++; $display("FAIL rnd_mdin c%0d: got %h want %h", i, bus.mem_din, exp_mdin); end
      n_vec++; if (bus.mem_funct3 !== exp_mf3) begin n_bad++; $display("FAIL rnd_mf3 c%0d: got %h want %h", i, bus.mem_funct3, exp_mf3); end
      n_vec++; if (bus.core_rdata !== smem[idx]) begin n_bad++; $display("FAIL rnd_core_rdata c%0d: got %h want %h", i, bus.core_rdata, smem[idx]); end
      n_vec++; if (bus.dbg_rvalid !== exp_rv) begin n_bad++; $display("FAIL rnd_rvalid c%0d: got %b want %b", i, bus.dbg_rvalid, exp_rv); end
      n_vec++; if (bus.dbg_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", i, bus.dbg_rdata, exp_rd); end
      advance();
      n_vec++; if (mem[idx] !== smem[idx]) begin n_bad++; $display("FAIL rnd_mem c%0d: got %h want %h", i, mem[idx], smem[idx]); end
    end
    reset = 0; set_idle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1; set_idle();
    eval_cycle(); advance();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h40;
      eval_cycle(); advance();
      bus.dbg_valid = 0;
      eval_cycle(); advance();
    end
    bus.dbg_valid = 1;
    for (int i = 0; i < LIM + 3; i++) begin
      bus.core_re = 1; bus.core_addr = 32'h80;
      eval_cycle(); advance();
      bus.dbg_valid = 0;
    end
    set_idle();
    eval_cycle();
    n_vec++; if (stat_grants !== 16'd4 || stat_grants !== m_grants) begin n_bad++; $display("FAIL stat_grants: got %0d want 4", stat_grants); end
    n_vec++; if (stat_stalls !== 16'd1 || stat_stalls !== m_stalls) begin n_bad++; $display("FAIL stat_stalls: got %0d want 1", stat_stalls); end
    advance();
  endtask
`endif

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1; mem_init = 1;
    set_idle();
    model_clear();
    for (int i = 0; i < 64; i++) smem[i] = 32'h0;
    @(posedge clk); #1;
    mem_init = 0;
    test_reset();
    test_idle_write_read();
    test_starve();
    test_core_load_pending();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
